// File: rtl/flag_status_unit_pkg.sv
// rtl/flag_status_unit_pkg.sv - shared types and constants for the condition-flag unit
// Purpose: flag bit positions, packed {z,c,n,v} flag struct and FSM state enum.
// Ports: none (package).
package flag_status_unit_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } flags_t;

  typedef enum logic {
    RUN   = 1'b0,
    SAVED = 1'b1
  } state_t;

endpackage

// File: rtl/flag_status_unit_flag_gen.sv
// rtl/flag_status_unit_flag_gen.sv - combinational N/Z/C/V generation from ALU results
// Purpose: builds the new flag value for an S-bit instruction in execute.
// Ports:
//   alu_result   [DATA_W-1:0] ALU result (Z from all-zero, N from MSB)
//   alu_carry    adder carry-out (C for arithmetic ops)
//   alu_overflow adder signed overflow (V for arithmetic ops)
//   shift_carry  shifter carry-out (C for logical ops)
//   ex_logical   logical op select
//   cur_v        current architectural-or-pending V, kept by logical ops
//   flags        generated flags {z,c,n,v}
module flag_gen
  import flag_status_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              shift_carry,
  input  logic              ex_logical,
  input  logic              cur_v,
  output flags_t            flags
);

  always_comb begin
    flags   = '0;
    flags.z = (alu_result == '0);
    flags.n = alu_result[DATA_W-1];
    flags.c = ex_logical ? shift_carry : alu_carry;
    flags.v = ex_logical ? cur_v : alu_overflow;
  end

endmodule

// File: rtl/flag_status_unit.sv
// rtl/flag_status_unit.sv - condition-flag producer: pending stage, status register, shadow
// Purpose: captures flags from S-bit instructions into a one-entry pending stage,
//   commits them to the status register on the following edge, supports direct
//   flag writes and a single-level shadow for exception entry/return.
// Config macro: FLAG_STATUS_BYPASS_EN (status_fwd forwards pending flags when defined).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_valid, ex_s, ex_logical execute-stage instruction qualifiers
//   alu_result, alu_carry, alu_overflow, shift_carry  ALU/shifter outputs
//   stall, flush               block capture / squash execute instruction
//   msr_we, msr_data           direct flag write {z,c,n,v}
//   exc_entry, exc_return      shadow save / restore
//   status_reg                 committed flags {z,c,n,v}
//   status_fwd                 flags seen by condition logic
//   flags_busy                 pending update not yet committed
module flag_status_unit
  import flag_status_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_s,
  input  logic              ex_logical,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              shift_carry,
  input  logic              stall,
  input  logic              flush,
  input  logic              msr_we,
  input  logic [3:0]        msr_data,
  input  logic              exc_entry,
  input  logic              exc_return,
  output logic [3:0]        status_reg,
  output logic [3:0]        status_fwd,
  output logic              flags_busy
);

  state_t state_q, state_d;
  flags_t status_q, status_d;
  flags_t pend_q, pend_d;
  flags_t shadow_q, shadow_d;
  logic   pend_valid_q, pend_valid_d;

  flags_t gen_flags;
  flags_t commit_val;
  logic   cur_v;
  logic   capture;

  // Logical ops preserve V as the newest known value, including an uncommitted one.
  assign cur_v      = pend_valid_q ? pend_q.v : status_q.v;
  assign commit_val = pend_valid_q ? pend_q : status_q;
  assign capture    = ex_valid & ex_s & ~stall & ~flush;

  flag_gen #(
    .DATA_W(DATA_W)
  ) u_flag_gen (
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .alu_overflow(alu_overflow),
    .shift_carry (shift_carry),
    .ex_logical  (ex_logical),
    .cur_v       (cur_v),
    .flags       (gen_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      status_q     <= '0;
      pend_q       <= '0;
      shadow_q     <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      pend_q       <= pend_d;
      shadow_q     <= shadow_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Priority: exc_return (SAVED) > exc_entry > msr_we > pending commit.
  // Any of the first three also drops a capture happening on the same edge.
  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    pend_d       = pend_q;
    shadow_d     = shadow_q;
    pend_valid_d = capture;

    if (capture) begin
      pend_d = gen_flags;
    end

    if (state_q == SAVED && exc_return) begin
      state_d      = RUN;
      status_d     = shadow_q;
      pend_valid_d = 1'b0;
    end else if (exc_entry) begin
      // The pending entry is folded into the status register so the shadow
      // and the architectural value agree at entry.
      state_d      = SAVED;
      shadow_d     = commit_val;
      status_d     = commit_val;
      pend_valid_d = 1'b0;
    end else if (msr_we) begin
      status_d     = flags_t'(msr_data);
      pend_valid_d = 1'b0;
    end else if (pend_valid_q) begin
      status_d = pend_q;
    end
  end

  assign status_reg = status_q;
  assign flags_busy = pend_valid_q;

`ifdef FLAG_STATUS_BYPASS_EN
  assign status_fwd = pend_valid_q ? pend_q : status_q;
`else
  assign status_fwd = status_q;
`endif

endmodule

// File: tb/tb_flag_status_unit.sv
// tb/tb_flag_status_unit.sv - directed self-checking bench for flag_status_unit
module tb_flag_status_unit;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_s;
  logic        ex_logical;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_overflow;
  logic        shift_carry;
  logic        stall;
  logic        flush;
  logic        msr_we;
  logic [3:0]  msr_data;
  logic        exc_entry;
  logic        exc_return;
  logic [3:0]  status_reg;
  logic [3:0]  status_fwd;
  logic        flags_busy;

  int n_checks;
  int n_fail;

`ifdef FLAG_STATUS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  flag_status_unit #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_s        (ex_s),
    .ex_logical  (ex_logical),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .alu_overflow(alu_overflow),
    .shift_carry (shift_carry),
    .stall       (stall),
    .flush       (flush),
    .msr_we      (msr_we),
    .msr_data    (msr_data),
    .exc_entry   (exc_entry),
    .exc_return  (exc_return),
    .status_reg  (status_reg),
    .status_fwd  (status_fwd),
    .flags_busy  (flags_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks status, busy and the forwarded view; pend is the expected pending value.
  task automatic chk(input string tag, input logic [3:0] st, input logic busy, input logic [3:0] pend);
    logic [3:0] fwd;
    fwd = (BYP && busy) ? pend : st;
    check({tag, ".status"}, {28'd0, status_reg}, {28'd0, st});
    check({tag, ".busy"}, {31'd0, flags_busy}, {31'd0, busy});
    check({tag, ".fwd"}, {28'd0, status_fwd}, {28'd0, fwd});
  endtask

  task automatic idle();
    ex_valid = 0; ex_s = 0; ex_logical = 0; alu_result = 0;
    alu_carry = 0; alu_overflow = 0; shift_carry = 0;
    stall = 0; flush = 0; msr_we = 0; msr_data = 0;
    exc_entry = 0; exc_return = 0;
  endtask

  task automatic ex_op(input logic logical, input logic [31:0] res,
                       input logic c, input logic v, input logic sc);
    ex_valid = 1; ex_s = 1; ex_logical = logical; alu_result = res;
    alu_carry = c; alu_overflow = v; shift_carry = sc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst_n = 0;
    #23;
    chk("reset", 4'b0000, 1'b0, 4'b0000);
    rst_n = 1;
    #1;

    // Z=1, C=1 from arithmetic op: 1100 after two edges, busy for one cycle.
    ex_op(0, 32'h0, 1, 0, 0);
    step();
    idle();
    chk("cap1_e1", 4'b0000, 1'b1, 4'b1100);
    step();
    chk("cap1_e2", 4'b1100, 1'b0, 4'b0000);
    step();
    chk("cap1_e3", 4'b1100, 1'b0, 4'b0000);

    // N=1, V=1 then logical op keeps V.
    ex_op(0, 32'h8000_0000, 0, 1, 0);
    step();
    ex_op(1, 32'h1, 1, 0, 0);
    step();
    idle();
    chk("nv_commit", 4'b0011, 1'b1, 4'b0001);
    step();
    chk("logic_v", 4'b0001, 1'b0, 4'b0000);

    // Flushed capture does nothing.
    ex_op(0, 32'h0, 1, 0, 0);
    flush = 1;
    step();
    idle();
    chk("flush_e1", 4'b0001, 1'b0, 4'b0000);
    step();
    chk("flush_e2", 4'b0001, 1'b0, 4'b0000);

    // Stalled capture does nothing.
    ex_op(0, 32'h0, 1, 0, 0);
    stall = 1;
    step();
    idle();
    chk("stall", 4'b0001, 1'b0, 4'b0000);

    // Capture then flush next cycle: the pending entry still commits.
    ex_op(0, 32'h0, 0, 0, 0);
    step();
    chk("pend_1000", 4'b0001, 1'b1, 4'b1000);
    ex_op(0, 32'h8000_0000, 1, 1, 0);
    flush = 1;
    step();
    idle();
    chk("flush_late", 4'b1000, 1'b0, 4'b0000);

    // msr_we on the same edge as commit of 0101 wins.
    ex_op(0, 32'h1, 1, 1, 0);
    step();
    idle();
    chk("pend_0101", 4'b1000, 1'b1, 4'b0101);
    msr_we = 1; msr_data = 4'b1010;
    step();
    idle();
    chk("msr_vs_commit", 4'b1010, 1'b0, 4'b0000);
    step();
    chk("msr_hold", 4'b1010, 1'b0, 4'b0000);

    // msr_we on the same edge as a capture drops the capture.
    ex_op(0, 32'h0, 1, 0, 0);
    msr_we = 1; msr_data = 4'b0110;
    step();
    idle();
    chk("msr_vs_cap", 4'b0110, 1'b0, 4'b0000);
    step();
    chk("msr_vs_cap2", 4'b0110, 1'b0, 4'b0000);

    // Shadow save / msr / restore.
    exc_entry = 1;
    step();
    idle();
    chk("exc_entry", 4'b0110, 1'b0, 4'b0000);
    msr_we = 1; msr_data = 4'b1001;
    step();
    idle();
    chk("saved_msr", 4'b1001, 1'b0, 4'b0000);
    exc_return = 1;
    step();
    idle();
    chk("exc_return", 4'b0110, 1'b0, 4'b0000);
    msr_we = 1; msr_data = 4'b1111;
    step();
    idle();
    exc_return = 1;
    step();
    idle();
    chk("ret_in_run", 4'b1111, 1'b0, 4'b0000);

    // exc_entry with a pending entry folds it into status and shadow.
    ex_op(0, 32'h0, 1, 0, 0);
    step();
    idle();
    exc_entry = 1;
    step();
    idle();
    chk("entry_pend", 4'b1100, 1'b0, 4'b0000);
    msr_we = 1; msr_data = 4'b0000;
    step();
    idle();
    exc_return = 1;
    step();
    idle();
    chk("entry_pend_ret", 4'b1100, 1'b0, 4'b0000);

    // Back-to-back S instructions commit in order.
    ex_op(0, 32'h8000_0000, 0, 0, 0);
    step();
    ex_op(0, 32'h5, 1, 0, 0);
    step();
    idle();
    chk("b2b_1", 4'b0010, 1'b1, 4'b0100);
    step();
    chk("b2b_2", 4'b0100, 1'b0, 4'b0000);

    // Asynchronous reset mid-cycle clears everything.
    ex_op(0, 32'h0, 1, 1, 0);
    step();
    idle();
    #2;
    rst_n = 0;
    #1;
    chk("async_rst", 4'b0000, 1'b0, 4'b0000);
    rst_n = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
